// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: host-side initiator for the 4-bit button-entry alu.
// Accepts one packed command (A, B, opcode) over valid/ready. It drives the alu operand and
// opcode lines, then issues five enter pulses that walk the alu through S0..S4 and back to S0.
// The alu result is captured after the fourth pulse and returned over a valid/ready channel.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake; cmd_a, cmd_b, cmd_oper carry the command
//   rsp_valid/rsp_ready           response handshake; rsp_result, rsp_err carry the response
//   alu_a, alu_b, alu_oper        operand and opcode lines to the alu
//   alu_enter, alu_rst            enter button and active-high reset to the alu
//   alu_result                    result from the alu
// All outputs are registered.
module alu_cmd_driver #(
  parameter int unsigned ENTER_HI   = 2,
  parameter int unsigned ENTER_LO   = 2,
  parameter int unsigned SETTLE     = 2,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_oper,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_err,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_oper,
  output logic       alu_enter,
  output logic       alu_rst,
  input  logic [7:0] alu_result
);

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StPressHi,
    StPressLo,
    StSettle,
    StResp
  } state_e;

  // Last phase-counter value of each timed state.
  localparam logic [7:0] HiLast     = 8'(ENTER_HI - 1);
  localparam logic [7:0] LoLast     = 8'(ENTER_LO - 1);
  localparam logic [7:0] SettleLast = 8'(SETTLE - 1);
  localparam logic [7:0] RstLast    = 8'(RST_CYCLES - 1);

  state_e     state_q;
  logic [7:0] phase_q;  // cycles spent in the current state, cleared on every state entry
  logic [2:0] press_q;  // number of the enter pulse in progress (1..5)

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StInit;
      phase_q    <= 8'd0;
      press_q    <= 3'd0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'd0;
      rsp_err    <= 1'b0;
      alu_a      <= 4'd0;
      alu_b      <= 4'd0;
      alu_oper   <= 4'd0;
      alu_enter  <= 1'b0;
      alu_rst    <= 1'b1;
    end else begin
      phase_q <= phase_q + 8'd1;
      unique case (state_q)
        StInit: begin
          if (phase_q == RstLast) begin
            alu_rst <= 1'b0;
            state_q <= StIdle;
            phase_q <= 8'd0;
          end
        end
        StIdle: begin
          // cmd_ready is registered, so it only rises the cycle after IDLE is entered.
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_oper  <= cmd_oper;
            rsp_err   <= (cmd_oper == 4'b0000) || (cmd_oper == 4'b1111) ||
                         ((cmd_oper == 4'b0100) && (cmd_b == 4'd0));
            cmd_ready <= 1'b0;
            press_q   <= 3'd1;
            alu_enter <= 1'b1;
            state_q   <= StPressHi;
            phase_q   <= 8'd0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        StPressHi: begin
          if (phase_q == HiLast) begin
            alu_enter <= 1'b0;
            state_q   <= StPressLo;
            phase_q   <= 8'd0;
          end
        end
        StPressLo: begin
          if (phase_q == LoLast) begin
            phase_q <= 8'd0;
            if (press_q == 3'd4) begin
              state_q <= StSettle;
            end else if (press_q == 3'd5) begin
              state_q <= StResp;
            end else begin
              press_q   <= press_q + 3'd1;
              alu_enter <= 1'b1;
              state_q   <= StPressHi;
            end
          end
        end
        StSettle: begin
          if (phase_q == SettleLast) begin
            rsp_result <= alu_result;
            // Fifth pulse returns the alu to S0 before the host sees the response.
            press_q    <= 3'd5;
            alu_enter  <= 1'b1;
            state_q    <= StPressHi;
            phase_q    <= 8'd0;
          end
        end
        StResp: begin
          // rsp_valid rises one cycle after entering RESP.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
            phase_q   <= 8'd0;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_q <= StInit;
          phase_q <= 8'd0;
          alu_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a small behavioural button-entry alu attached.
module tb_alu_cmd_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = 4'd0, cmd_b = 4'd0, cmd_oper = 4'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic [3:0] alu_a, alu_b, alu_oper;
  logic       alu_enter, alu_rst;
  logic [7:0] alu_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_cmd_driver dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_oper   (cmd_oper),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_oper   (alu_oper),
    .alu_enter  (alu_enter),
    .alu_rst    (alu_rst),
    .alu_result (alu_result)
  );

  // Behavioural alu: press 1 latches A, 2 latches B, 3 latches opcode, 4 shows the result,
  // 5 returns to S0.
  logic       enter_q = 1'b0;
  int         hi_run = 0, bad_width = 0, pulses = 0, cyc = 0, overlap = 0;
  logic [2:0] st = 3'd0;
  logic [3:0] ma = 4'd0, mb = 4'd0, mop = 4'd0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    enter_q <= alu_enter;
    hi_run  <= alu_enter ? hi_run + 1 : 0;
    if (!alu_enter && enter_q && hi_run != 2) bad_width <= bad_width + 1;
    if (alu_enter && !enter_q) pulses <= pulses + 1;
    if (alu_rst) begin
      st <= 3'd0;
    end else if (alu_enter && !enter_q) begin
      case (st)
        3'd0: begin ma <= alu_a; st <= 3'd1; end
        3'd1: begin mb <= alu_b; st <= 3'd2; end
        3'd2: begin mop <= alu_oper; st <= 3'd3; end
        3'd3: st <= 3'd4;
        default: st <= 3'd0;
      endcase
    end
  end

  always_comb begin
    alu_result = 8'd0;
    if (st == 3'd4) begin
      case (mop)
        4'h1: alu_result = {4'd0, ma} + {4'd0, mb};
        4'h2: alu_result = {4'd0, ma} - {4'd0, mb};
        4'h3: alu_result = {4'd0, ma} * {4'd0, mb};
        4'h4: alu_result = (mb != 4'd0) ? {4'd0, ma / mb} : 8'd0;
        4'h7: alu_result = {4'd0, ma} << mb;
        default: alu_result = 8'd0;
      endcase
    end
  end

  always @(negedge clk) if (rsp_valid && cmd_ready) overlap <= overlap + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  int p0, w0, acc_cyc;

  // Returns just after the accepting edge.
  task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq("cmd_ready_wait", {31'd0, cmd_ready}, 1);
    cmd_a = a; cmd_b = b; cmd_oper = op; cmd_valid = 1'b1;
    p0 = pulses; w0 = bad_width;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
    cmd_a = ~a; cmd_b = ~b; cmd_oper = ~op;
  endtask

  task automatic wait_rsp(input string tag, input logic [7:0] exp_res, input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, {31'd0, rsp_valid}, 1);
    check_eq({tag, "_latency"}, cyc - acc_cyc, 23);
    check_eq({tag, "_pulses"}, pulses - p0, 5);
    check_eq({tag, "_width"}, bad_width - w0, 0);
    check_eq({tag, "_result"}, {24'd0, rsp_result}, {24'd0, exp_res});
    check_eq({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  // Entered at a negedge with rsp_valid high.
  task automatic finish_rsp(input string tag, input int stall);
    logic [7:0] r0 = rsp_result;
    int bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_result != r0 || alu_enter || cmd_ready) bad++;
    end
    check_eq({tag, "_stall"}, bad, 0);
    check_eq({tag, "_no_extra"}, pulses - p0, 5);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, "_rsp_drop"}, {30'd0, rsp_valid, cmd_ready}, 0);
    @(negedge clk);
    check_eq({tag, "_ready_back"}, {31'd0, cmd_ready}, 1);
  endtask

  initial begin
    int n;
    int ent;
    #22;
    check_eq("rst_values", {17'd0, alu_rst, cmd_ready, rsp_valid, alu_enter, rsp_err, alu_a,
             rsp_result}, {17'd0, 5'b10000, 4'd0, 8'd0});

    // Reset release: alu_rst high for exactly four cycles, then cmd_ready.
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; ent = 0;
    while (alu_rst && n < 50) begin
      @(negedge clk);
      n++;
      if (alu_enter) ent++;
    end
    check_eq("alu_rst_cycles", n, 4);
    check_eq("init_no_ready", {31'd0, cmd_ready}, 0);
    @(negedge clk);
    check_eq("init_ready", {31'd0, cmd_ready}, 1);
    check_eq("init_no_enter", ent, 0);

    // Add, with a busy command poked during PRESS_HI.
    send_cmd(4'd7, 4'd9, 4'b0001);
    @(negedge clk);
    check_eq("press_hi_enter", {31'd0, alu_enter}, 1);
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_oper = 4'b0011; cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("busy_ignored_a", {28'd0, alu_a}, 7);
    wait_rsp("add", 8'd16, 1'b0);
    finish_rsp("add", 0);

    // Multiply with ten cycles of response backpressure.
    send_cmd(4'd15, 4'd15, 4'b0011);
    wait_rsp("mul", 8'd225, 1'b0);
    finish_rsp("mul", 10);

    send_cmd(4'd5, 4'd3, 4'b0111);
    wait_rsp("shl", 8'd40, 1'b0);
    finish_rsp("shl", 0);

    send_cmd(4'd6, 4'd0, 4'b0100);
    wait_rsp("div0", 8'd0, 1'b1);
    finish_rsp("div0", 0);

    send_cmd(4'd2, 4'd3, 4'b1111);
    wait_rsp("illegal", 8'd0, 1'b1);
    finish_rsp("illegal", 0);

    // Asynchronous reset during the third pulse.
    send_cmd(4'd9, 4'd9, 4'b0001);
    n = 0;
    while (pulses - p0 < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("third_pulse", pulses - p0, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_values", {19'd0, alu_rst, alu_enter, cmd_ready, rsp_valid, alu_a, alu_oper},
             {19'd0, 4'b1000, 4'd0, 4'd0});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
      if (rsp_valid) ent++;
    end
    check_eq("abort_no_rsp", ent, 0);
    check_eq("abort_reinit", n, 5);

    send_cmd(4'd3, 4'd4, 4'b0001);
    wait_rsp("post_abort", 8'd7, 1'b0);
    finish_rsp("post_abort", 0);

    check_eq("valid_ready_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
